// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
// Each line bit lasts CLK_FREQ/BAUD clocks; the byte is taken in through a valid/ready handshake.
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = 1'(PARITY_ODD);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    data_reg, data_next;
    logic          tx_reg, tx_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          bit_end;
    logic          parity_bit;

    assign bit_end    = (cnt_reg == CNT_LAST);
    assign parity_bit = (^data_reg) ^ PAR_ODD;

    // Ready is forced low while reset is held, even though the state already reads IDLE.
    assign din_ready = rst && (state_reg == IDLE);
    assign tx        = tx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        tx_next    = tx_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        if (state_reg != IDLE) begin
            cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (din_valid && din_ready) begin
                    data_next  = din;
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                    idx_next   = 3'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tx_next    = data_reg[0];
                    idx_next   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_reg == 3'd7) begin
                        idx_next = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        tx_next  = data_reg[idx_reg + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                    idx_next   = 3'd0;
                end
            end
            STOP: begin
                // The bit index is reused to count stop bits.
                if (bit_end) begin
                    if (idx_reg == STOP_LAST) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        idx_next   = 3'd0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                cnt_next   = '0;
                idx_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            data_reg  <= 8'd0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four transmitter configurations run side by side against a frame-level model,
// with directed literal frames, a mid-frame reset, back-to-back sends and a loopback receiver.
module tb_uart_tx;

    localparam int CPB = 16;
    localparam int NI  = 4;
    // Instance configs: 0 = no parity/1 stop, 1 = even/1 stop, 2 = odd/1 stop, 3 = no parity/2 stop
    localparam logic [3:0] CFG_PEN  = 4'b0110;
    localparam logic [3:0] CFG_PODD = 4'b0100;
    localparam logic [3:0] CFG_S2   = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din [NI];
    logic       din_valid [NI];
    logic       din_ready [NI];
    logic       tx [NI];
    logic       busy [NI];
    logic       done [NI];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            uart_tx #(
                .CLK_FREQ  (160),
                .BAUD      (10),
                .PARITY_EN (int'(CFG_PEN[gi])),
                .PARITY_ODD(int'(CFG_PODD[gi])),
                .STOP_BITS (CFG_S2[gi] ? 2 : 1)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .din      (din[gi]),
                .din_valid(din_valid[gi]),
                .din_ready(din_ready[gi]),
                .tx       (tx[gi]),
                .busy     (busy[gi]),
                .done     (done[gi])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", name, idx, cyc, act, exp);
        end
    endtask

    // Frame as a list of line bits: bit k of the result is line bit k.
    function automatic logic [11:0] build_frame(input logic [7:0] d, input int i);
        logic [11:0] f;
        int n;
        f = '0;
        f[8:1] = d;
        n = 9;
        if (CFG_PEN[i]) begin
            f[9] = (^d) ^ CFG_PODD[i];
            n = 10;
        end
        f[n]   = 1'b1;
        f[n+1] = 1'b1;
        return f;
    endfunction

    function automatic int frame_bits(input int i);
        return 9 + int'(CFG_PEN[i]) + (CFG_S2[i] ? 2 : 1);
    endfunction

    // Model: remaining clocks of the current frame; zero means the line is idle.
    int          rem [NI];
    int          flen [NI];
    logic [11:0] frame [NI];
    logic        done_exp [NI];
    int          acc_cnt [NI];
    int          acc_cyc [NI];
    logic [7:0]  last_byte [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            rem[i] = 0; flen[i] = 0; frame[i] = '0; done_exp[i] = 1'b0;
            acc_cnt[i] = 0; acc_cyc[i] = 0; last_byte[i] = 8'd0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            done_exp[i] = 1'b0;
            if (!rst) begin
                rem[i] = 0;
            end else if (rem[i] != 0) begin
                rem[i]--;
                if (rem[i] == 0) done_exp[i] = 1'b1;
            end else if (din_valid[i]) begin
                frame[i]     = build_frame(din[i], i);
                flen[i]      = frame_bits(i) * CPB;
                rem[i]       = flen[i];
                last_byte[i] = din[i];
                acc_cyc[i]   = cyc;
                acc_cnt[i]++;
            end
        end
    end

    // Compare process plus per-frame monitors and a loopback receiver on instance 0.
    logic        exp_tx;
    int          off;
    int          seen_acc [NI];
    logic [11:0] cap [NI];
    int          busy_cnt [NI];
    int          done_off [NI];
    int          done_cnt [NI];
    logic        rx_busy = 1'b0;
    int          rx_t = 0;
    logic [7:0]  rx_sh = 8'd0;
    logic [7:0]  rx_exp = 8'd0;
    int          rx_cnt = 0;
    int          rx_start_cyc = 0;
    int          rx_prev_start = 0;

    initial begin
        for (int i = 0; i < NI; i++) begin
            seen_acc[i] = 0; cap[i] = '0; busy_cnt[i] = 0; done_off[i] = -1; done_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                check("tx_rst", i, 32'(tx[i]), 32'd1);
                check("busy_rst", i, 32'(busy[i]), 32'd0);
                check("done_rst", i, 32'(done[i]), 32'd0);
                check("ready_rst", i, 32'(din_ready[i]), 32'd0);
            end else begin
                exp_tx = (rem[i] == 0) ? 1'b1 : frame[i][(flen[i] - rem[i]) / CPB];
                check("tx", i, 32'(tx[i]), 32'(exp_tx));
                check("busy", i, 32'(busy[i]), 32'(rem[i] != 0));
                check("done", i, 32'(done[i]), 32'(done_exp[i]));
                check("ready", i, 32'(din_ready[i]), 32'(rem[i] == 0));
                if (acc_cnt[i] != seen_acc[i]) begin
                    seen_acc[i] = acc_cnt[i];
                    cap[i]      = '0;
                    busy_cnt[i] = 0;
                    done_off[i] = -1;
                end
                off = cyc - acc_cyc[i];
                if (busy[i]) busy_cnt[i]++;
                if (rem[i] != 0 && (off % CPB) == CPB / 2 && (off / CPB) < 12)
                    cap[i][off / CPB] = tx[i];
                if (done[i]) begin
                    done_off[i] = off;
                    done_cnt[i]++;
                end
            end
        end

        if (!rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx[0] == 1'b0) begin
                rx_busy       = 1'b1;
                rx_t          = 0;
                rx_exp        = last_byte[0];
                rx_prev_start = rx_start_cyc;
                rx_start_cyc  = cyc;
            end
        end else begin
            rx_t++;
            if ((rx_t % CPB) == CPB / 2) begin
                if (rx_t / CPB == 0) begin
                    check("rx_start", 0, 32'(tx[0]), 32'd0);
                end else if (rx_t / CPB <= 8) begin
                    rx_sh[rx_t / CPB - 1] = tx[0];
                end else begin
                    check("rx_stop", 0, 32'(tx[0]), 32'd1);
                    check("rx_byte", 0, 32'(rx_sh), 32'(rx_exp));
                    rx_cnt++;
                    rx_busy = 1'b0;
                end
            end
        end
    end

    int drv_seen [NI];
    int acc_base;
    int rx_base;
    bit ok;

    initial begin
        for (int i = 0; i < NI; i++) begin
            din[i] = 8'd0;
            din_valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) check("ready_after_rst", i, 32'(din_ready[i]), 32'd1);

        // Literal frames: A5 plain, 07 even/odd parity, 00 with two stop bits
        din[0] = 8'hA5; din[1] = 8'h07; din[2] = 8'h07; din[3] = 8'h00;
        for (int i = 0; i < NI; i++) din_valid[i] = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) din_valid[i] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk); #1;
            ok = (done_cnt[0] >= 1) && (done_cnt[1] >= 1) && (done_cnt[2] >= 1) && (done_cnt[3] >= 1);
        end
        check("directed_timeout", 0, 32'(ok), 32'd1);
        check("frame_a5", 0, 32'(cap[0]), 32'h34A);
        check("done_off_a5", 0, done_off[0], 160);
        check("busy_len_a5", 0, busy_cnt[0], 160);
        check("frame_07_even", 1, 32'(cap[1]), 32'h60E);
        check("done_off_even", 1, done_off[1], 176);
        check("frame_07_odd", 2, 32'(cap[2]), 32'h40E);
        check("done_off_odd", 2, done_off[2], 176);
        check("frame_00_stop2", 3, 32'(cap[3]), 32'h600);
        check("done_off_stop2", 3, done_off[3], 176);
        check("busy_len_stop2", 3, busy_cnt[3], 176);
        repeat (3) @(negedge clk); #1;

        // Back-to-back with din_valid held; din changes right after the first accept
        din[0] = 8'h55; din_valid[0] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 5 && !ok; k++) begin
            @(negedge clk); #1;
            ok = (acc_cnt[0] == 2);
        end
        check("b2b_accept1_timeout", 0, 32'(ok), 32'd1);
        din[0] = 8'hC3;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk); #1;
            ok = (done_cnt[0] >= 2);
        end
        check("b2b_done_timeout", 0, 32'(ok), 32'd1);
        check("frame_55", 0, 32'(cap[0]), 32'h2AA);
        ok = 1'b0;
        for (int k = 0; k < 5 && !ok; k++) begin
            @(negedge clk); #1;
            ok = (acc_cnt[0] == 3);
        end
        check("b2b_accept2_timeout", 0, 32'(ok), 32'd1);
        din_valid[0] = 1'b0;
        check("b2b_start_gap", 0, rx_start_cyc - rx_prev_start, 161);
        repeat (200) @(negedge clk); #1;

        // Mid-frame reset on every instance
        for (int i = 0; i < NI; i++) begin
            din[i] = 8'($urandom);
            din_valid[i] = 1'b1;
        end
        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) din_valid[i] = 1'b0;
        repeat (40) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("tx_at_rst", i, 32'(tx[i]), 32'd1);
            check("busy_at_rst", i, 32'(busy[i]), 32'd0);
            check("done_at_rst", i, 32'(done[i]), 32'd0);
        end
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (40) @(negedge clk); #1;
        for (int i = 0; i < NI; i++) check("ready_idle_after_abort", i, 32'(din_ready[i]), 32'd1);

        // Random traffic on all instances; instance 0 also feeds the loopback receiver
        acc_base = acc_cnt[0];
        rx_base  = rx_cnt;
        for (int i = 0; i < NI; i++) drv_seen[i] = acc_cnt[i];
        ok = 1'b0;
        for (int k = 0; k < 20000 && !ok; k++) begin
            @(negedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (acc_cnt[i] != drv_seen[i]) begin
                    drv_seen[i]  = acc_cnt[i];
                    din[i]       = 8'($urandom);
                    din_valid[i] = ($urandom_range(1, 0) == 1);
                end else if (!din_valid[i]) begin
                    din[i] = 8'($urandom);
                    if ($urandom_range(15, 0) == 0) din_valid[i] = 1'b1;
                end
            end
            ok = (acc_cnt[0] - acc_base) >= 16;
        end
        check("random_timeout", 0, 32'(ok), 32'd1);
        for (int i = 0; i < NI; i++) din_valid[i] = 1'b0;
        repeat (200) @(negedge clk); #1;
        check("loopback_count", 0, rx_cnt - rx_base, acc_cnt[0] - acc_base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
